mac_enc: RTL and testbench

MAC_ENC -- requirements
Module: mac_enc

---
 rtl/mac_pkg.sv | 42 ++++
 rtl/mac_crc32.sv | 26 ++
 rtl/mac_enc.sv | 176 +++++++++++++++++
 tb/tb_mac_enc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC transmit encoder: state encoding, frame
// limits, header field layout and the reflected CRC-32 byte update.
package mac_pkg;
  localparam int NUM_PORTS    = 4;
  localparam int PORT_W       = 2;
  localparam int MAC_W        = 48;
  localparam int TYPE_W       = 16;
  localparam int HDR_W        = 114;
  localparam int HDR_BITS     = 112;
  localparam int HDR_PORT_LSB = 112;
  localparam int HDR_DST_LSB  = 64;
  localparam int HDR_SRC_LSB  = 16;
  localparam int HDR_TYPE_LSB = 0;

  localparam logic [10:0] MIN_FRAME   = 11'd60;
  localparam logic [10:0] MAX_PAYLOAD = 11'd1500;
  localparam logic [3:0]  HDR_LEN     = 4'd14;
  localparam logic [3:0]  PRE_LEN     = 4'd7;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PAD     = 3'd4,
    S_FCS     = 3'd5,
    S_END     = 3'd6
  } state_e;

  // LSB-first (reflected) CRC-32 advanced by one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/mac_crc32.sv
// Running Ethernet CRC-32 register, one byte per enabled cycle, with a
// synchronous clear back to the initial value.
module mac_crc32
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, data);
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;

  assign crc = crc_q;
endmodule

// File: rtl/mac_enc.sv
// Ethernet TX framer: header + payload + zero pad + FCS into one of four PHY
// FIFOs. Define MAC_ENC_PREAMBLE_EN to prepend the 7x55/D5 preamble.
module mac_enc
  import mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [HDR_W-1:0]     h_fifo_dout,
  input  logic                 h_fifo_empty,
  output logic                 h_fifo_rden,
  input  logic [7:0]           b_fifo_dout,
  input  logic                 b_fifo_empty,
  input  logic                 b_fifo_del,
  output logic                 b_fifo_rden,
  output logic [7:0]           o_fifo_din,
  output logic [NUM_PORTS-1:0] o_fifo_wren,
  output logic                 o_fifo_del,
  input  logic [NUM_PORTS-1:0] o_fifo_afull
);
`ifdef MAC_ENC_PREAMBLE_EN
  localparam state_e FIRST_STATE = S_PRE;
`else
  localparam state_e FIRST_STATE = S_HEADER;
`endif

  state_e                state_q, state_d;
  logic [HDR_BITS-1:0]   hdr_q, hdr_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [3:0]            idx_q, idx_d;
  logic [10:0]           pay_q, pay_d, frm_q, frm_d;
  logic [7:0]            din_q, din_d;
  logic [NUM_PORTS-1:0]  wren_q, wren_d, port_oh;
  logic                  del_q, del_d, h_rden_q, h_rden_d, b_rden_q, b_rden_d;
  logic                  crc_en, crc_clr, accept, take, keep, short_frm;
  logic [PORT_W-1:0]     req_port;
  logic [31:0]           crc, fcs;

  assign req_port = h_fifo_dout[HDR_PORT_LSB +: PORT_W];
  assign accept   = !h_fifo_empty && !o_fifo_afull[req_port];
  // rden is registered, so the byte popped last cycle is still on dout: skip it.
  assign take      = (state_q == S_PAYLOAD) && !b_rden_q && !b_fifo_empty;
  assign keep      = (pay_q < MAX_PAYLOAD);
  assign short_frm = ((frm_q + {10'd0, keep}) < MIN_FRAME);
  assign fcs       = ~crc;

  always_comb begin
    port_oh = '0;
    port_oh[port_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = FIRST_STATE;
      S_PRE:     if (idx_q == PRE_LEN) state_d = S_HEADER;
      S_HEADER:  if (idx_q == HDR_LEN - 4'd1) state_d = S_PAYLOAD;
      S_PAYLOAD: if (take && b_fifo_del) state_d = short_frm ? S_PAD : S_FCS;
      S_PAD:     if (frm_q == MIN_FRAME - 11'd1) state_d = S_FCS;
      S_FCS:     if (idx_q == 4'd3) state_d = S_END;
      S_END:     state_d = S_IDLE;
      default:   state_d = S_END;
    endcase
  end

  always_comb begin
    hdr_d    = hdr_q;
    port_d   = port_q;
    idx_d    = idx_q;
    pay_d    = pay_q;
    frm_d    = frm_q;
    din_d    = 8'h00;
    wren_d   = '0;
    del_d    = 1'b0;
    h_rden_d = 1'b0;
    b_rden_d = 1'b0;
    crc_en   = 1'b0;
    crc_clr  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        hdr_d    = {h_fifo_dout[HDR_DST_LSB +: MAC_W], h_fifo_dout[HDR_SRC_LSB +: MAC_W],
                    h_fifo_dout[HDR_TYPE_LSB +: TYPE_W]};
        port_d   = req_port;
        h_rden_d = 1'b1;
        idx_d    = '0;
        pay_d    = '0;
        frm_d    = '0;
      end
      S_PRE: begin
        din_d  = (idx_q == PRE_LEN) ? 8'hD5 : 8'h55;
        wren_d = port_oh;
        idx_d  = (idx_q == PRE_LEN) ? 4'd0 : idx_q + 4'd1;
      end
      S_HEADER: begin
        din_d  = hdr_q[HDR_BITS-1 -: 8];
        hdr_d  = hdr_q << 8;
        wren_d = port_oh;
        crc_en = 1'b1;
        frm_d  = frm_q + 11'd1;
        idx_d  = (idx_q == HDR_LEN - 4'd1) ? 4'd0 : idx_q + 4'd1;
      end
      S_PAYLOAD: if (take) begin
        b_rden_d = 1'b1;
        if (pay_q != 11'h7FF) pay_d = pay_q + 11'd1;
        // Bytes past the payload limit are drained but never transmitted.
        if (keep) begin
          din_d  = b_fifo_dout;
          wren_d = port_oh;
          crc_en = 1'b1;
          frm_d  = frm_q + 11'd1;
        end
      end
      S_PAD: begin
        wren_d = port_oh;
        crc_en = 1'b1;
        frm_d  = frm_q + 11'd1;
      end
      S_FCS: begin
        din_d  = fcs[{idx_q[1:0], 3'b000} +: 8];
        wren_d = port_oh;
        del_d  = (idx_q == 4'd3);
        idx_d  = (idx_q == 4'd3) ? 4'd0 : idx_q + 4'd1;
      end
      S_END: begin
        crc_clr = 1'b1;
        idx_d   = '0;
        pay_d   = '0;
        frm_d   = '0;
      end
      default: crc_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      hdr_q    <= '0;
      port_q   <= '0;
      idx_q    <= '0;
      pay_q    <= '0;
      frm_q    <= '0;
      din_q    <= 8'h00;
      wren_q   <= '0;
      del_q    <= 1'b0;
      h_rden_q <= 1'b0;
      b_rden_q <= 1'b0;
    end else begin
      hdr_q    <= hdr_d;
      port_q   <= port_d;
      idx_q    <= idx_d;
      pay_q    <= pay_d;
      frm_q    <= frm_d;
      din_q    <= din_d;
      wren_q   <= wren_d;
      del_q    <= del_d;
      h_rden_q <= h_rden_d;
      b_rden_q <= b_rden_d;
    end

  mac_crc32 u_crc (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .data   (din_d),
    .crc    (crc)
  );

  assign h_fifo_rden = h_rden_q;
  assign b_fifo_rden = b_rden_q;
  assign o_fifo_din  = din_q;
  assign o_fifo_wren = wren_q;
  assign o_fifo_del  = del_q;
endmodule

// File: tb/tb_mac_enc.sv
// Bench for mac_enc: queue-backed header/body FIFOs, a byte-list frame model
// with bit-serial CRC, and a per-cycle output compare.
module tb_mac_enc;
`ifdef MAC_ENC_PREAMBLE_EN
  localparam int PRE_N = 8;
`else
  localparam int PRE_N = 0;
`endif

  logic         clk = 1'b0;
  logic         arst_n;
  logic [113:0] h_fifo_dout = '0;
  logic         h_fifo_empty = 1'b1;
  logic         h_fifo_rden;
  logic [7:0]   b_fifo_dout = '0;
  logic         b_fifo_empty = 1'b1;
  logic         b_fifo_del = 1'b0;
  logic         b_fifo_rden;
  logic [7:0]   o_fifo_din;
  logic [3:0]   o_fifo_wren;
  logic         o_fifo_del;
  logic [3:0]   o_fifo_afull;

  mac_enc dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
    .b_fifo_dout(b_fifo_dout), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
    .b_fifo_rden(b_fifo_rden),
    .o_fifo_din(o_fifo_din), .o_fifo_wren(o_fifo_wren), .o_fifo_del(o_fifo_del),
    .o_fifo_afull(o_fifo_afull)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int brd_cnt = 0, hrd_cnt = 0, frames_done = 0, first_cyc = 0;
  int exp_len = 0, last_len = 0;
  logic [3:0]   exp_wren = '0, last_wren = '0;
  logic         stall = 1'b0, stall_chk = 1'b0, b_pop = 1'b0, h_pop = 1'b0;
  logic [8:0]   bq[$];
  logic [113:0] hq[$];
  logic [7:0]   exp_q[$], got[$], last_frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%s expected=%s", name, act, exp);
  endtask

  // Reflected CRC register after feeding bytes LSB-first, no final inversion.
  function automatic logic [31:0] crc_raw(input logic [7:0] d[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return c;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Show-ahead FIFOs: pops seen mid-cycle take effect at the following edge.
  always @(posedge clk) begin
    #2;
    if (b_pop) begin
      if (bq.size() > 0) void'(bq.pop_front());
      else fail("b_underflow", "pop_on_empty", "data");
    end
    if (h_pop) begin
      if (hq.size() > 0) void'(hq.pop_front());
      else fail("h_underflow", "pop_on_empty", "data");
    end
    b_fifo_empty = (bq.size() == 0) || stall;
    {b_fifo_del, b_fifo_dout} = (bq.size() > 0) ? bq[0] : 9'h0;
    h_fifo_empty = (hq.size() == 0);
    h_fifo_dout  = (hq.size() > 0) ? hq[0] : '0;
  end

  always @(negedge clk) begin
    logic [7:0]  e;
    logic [7:0]  body[$];
    b_pop = b_fifo_rden;
    h_pop = h_fifo_rden;
    if (b_fifo_rden) brd_cnt++;
    if (h_fifo_rden) hrd_cnt++;
    if (stall_chk) check("stall_wren", {28'h0, o_fifo_wren}, 32'h0);
    if (o_fifo_wren != 4'h0) begin
      if (got.size() == 0) first_cyc = cyc;
      if (exp_q.size() == 0) fail("extra_byte", "byte_written", "no_byte");
      else begin
        e = exp_q.pop_front();
        check("din", {24'h0, o_fifo_din}, {24'h0, e});
        check("wren", {28'h0, o_fifo_wren}, {28'h0, exp_wren});
        check("del", {31'h0, o_fifo_del}, {31'h0, exp_q.size() == 0});
      end
      got.push_back(o_fifo_din);
      if (o_fifo_del) begin
        body = got;
        for (int i = 0; i < PRE_N; i++) void'(body.pop_front());
        check("residue", bitrev(crc_raw(body)), 32'hC704_DD7B);
        check("frame_len", got.size(), exp_len);
        last_frame = got;
        last_len   = got.size();
        last_wren  = o_fifo_wren;
        got.delete();
        frames_done++;
      end
    end else if (o_fifo_del) fail("del_no_wren", "del=1", "del=0");
  end

  // Builds the expected wire bytes for a frame and loads both input FIFOs.
  task automatic send_frame(input logic [1:0] port, input int n, input int kind);
    logic [7:0]  pay[$], frm[$];
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic [31:0] fcs;
    dst = 48'h0200_0000_0010 + {46'h0, port};
    src = 48'h0000_5E00_5301;
    typ = 16'h88B5;
    for (int i = 0; i < n; i++) pay.push_back(kind == 0 ? 8'hAA : 8'(i * 7 + 3));
    for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    for (int i = 0; i < n && i < 1500; i++) frm.push_back(pay[i]);
    while (frm.size() < 60) frm.push_back(8'h00);
    fcs = ~crc_raw(frm);
    for (int i = 0; i < 4; i++) frm.push_back(fcs[i*8 +: 8]);
    exp_q.delete();
`ifdef MAC_ENC_PREAMBLE_EN
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
`endif
    foreach (frm[i]) exp_q.push_back(frm[i]);
    exp_len  = exp_q.size();
    exp_wren = 4'b0001 << port;
    for (int i = 0; i < n; i++) bq.push_back({i == n - 1, pay[i]});
    hq.push_back({port, dst, src, typ});
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = frames_done;
    for (int i = 0; i < budget && frames_done == start; i++) @(posedge clk);
    if (frames_done == start) fail("frame_timeout", "no_del", "del");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int nb, input int budget);
    for (int i = 0; i < budget && got.size() < nb; i++) begin
      @(posedge clk);
      #1;
    end
    if (got.size() < nb) fail("byte_timeout", "too_few_bytes", "enough_bytes");
  endtask

  initial begin
    logic [7:0] s[$];
    int r0, t0;
    arst_n = 1'b0;
    o_fifo_afull = 4'h0;

    for (int i = 0; i < 9; i++) s.push_back(8'(8'h31 + i));
    check("model_crc_check", ~crc_raw(s), 32'hCBF4_3926);

    repeat (3) @(negedge clk);
    check("rst_h_rden", {31'h0, h_fifo_rden}, 32'h0);
    check("rst_b_rden", {31'h0, b_fifo_rden}, 32'h0);
    check("rst_wren", {28'h0, o_fifo_wren}, 32'h0);
    check("rst_din", {24'h0, o_fifo_din}, 32'h0);
    check("rst_del", {31'h0, o_fifo_del}, 32'h0);
    @(posedge clk);
    #1 arst_n = 1'b1;

    r0 = brd_cnt;
    send_frame(2'd2, 1, 0);
    wait_done(400);
    check("t1_len", last_len, 64 + PRE_N);
    check("t1_payload", {24'h0, last_frame[PRE_N + 14]}, 32'hAA);
    check("t1_pad", {24'h0, last_frame[PRE_N + 59]}, 32'h0);
    check("t1_wren", {28'h0, last_wren}, 32'h4);
    check("t1_rden", brd_cnt - r0, 1);

    send_frame(2'd0, 100, 1);
    wait_done(800);
    check("t2_len", last_len, 118 + PRE_N);
`ifdef MAC_ENC_PREAMBLE_EN
    check("t2_pre0", {24'h0, last_frame[0]}, 32'h55);
    check("t2_sfd", {24'h0, last_frame[7]}, 32'hD5);
`endif

    send_frame(2'd3, 100, 1);
    wait_bytes(PRE_N + 14 + 30, 400);
    stall = 1'b1;
    @(posedge clk);
    #1 stall_chk = 1'b1;
    repeat (9) @(posedge clk);
    #1 stall = 1'b0;
    @(posedge clk);
    #1 stall_chk = 1'b0;
    wait_done(800);
    check("t3_len", last_len, 118 + PRE_N);

    o_fifo_afull = 4'b0010;
    r0 = hrd_cnt;
    send_frame(2'd1, 20, 1);
    repeat (5) @(negedge clk);
    check("t4_no_pop", hrd_cnt - r0, 0);
    check("t4_no_wren", {28'h0, o_fifo_wren}, 32'h0);
    @(posedge clk);
    #1 o_fifo_afull = 4'b0000;
    t0 = cyc;
    wait_done(400);
    check("t4_latency", first_cyc - t0, 2);
    check("t4_pop", hrd_cnt - r0, 1);
    check("t4_len", last_len, 64 + PRE_N);

    r0 = brd_cnt;
    send_frame(2'd0, 1600, 1);
    wait_done(6000);
    check("t5_len", last_len, 1518 + PRE_N);
    check("t5_rden", brd_cnt - r0, 1600);

    send_frame(2'd2, 100, 1);
    wait_bytes(PRE_N + 14 + 30, 400);
    arst_n = 1'b0;
    #1;
    check("t6_wren", {28'h0, o_fifo_wren}, 32'h0);
    check("t6_din", {24'h0, o_fifo_din}, 32'h0);
    check("t6_del", {31'h0, o_fifo_del}, 32'h0);
    check("t6_b_rden", {31'h0, b_fifo_rden}, 32'h0);
    check("t6_h_rden", {31'h0, h_fifo_rden}, 32'h0);
    @(posedge clk);
    #3;
    bq.delete();
    hq.delete();
    exp_q.delete();
    got.delete();
    @(posedge clk);
    @(posedge clk);
    #1 arst_n = 1'b1;
    send_frame(2'd1, 5, 1);
    wait_done(400);
    check("t6_len", last_len, 64 + PRE_N);
    check("t6_wren_after", {28'h0, last_wren}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
